// File: rtl/tl_sched.sv
// Timed traffic-light scheduler for a two-street intersection.
// Street A and street B have green phases with a minimum length.
// Yellow and all-red clearance phases sit between the greens.
// Latched pedestrian requests are served in an all-red WALK phase.
// Optional feature macro: TL_SCHED_EMERG_EN adds the emerg input and an
// all-red EMG preempt state.
module tl_sched #(
  parameter int GREEN_MIN = 8,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int PED_T     = 6,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       ped_req,
`ifdef TL_SCHED_EMERG_EN
  input  logic       emerg,
`endif
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       walk,
  output logic       ped_ack
);

  typedef enum logic [2:0] {
    S_AG  = 3'd0,
    S_AY  = 3'd1,
    S_AR1 = 3'd2,
    S_BG  = 3'd3,
    S_BY  = 3'd4,
    S_AR2 = 3'd5,
    S_PED = 3'd6
`ifdef TL_SCHED_EMERG_EN
    , S_EMG = 3'd7
`endif
  } state_t;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;
  localparam logic       DIR_A       = 1'b1;
  localparam logic       DIR_B       = 1'b0;

  // Last timer value of each phase; a phase of length N leaves when timer==N-1.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_T - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX   = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic             ped_pend_reg, ped_pend_next;
  logic             next_dir_reg, next_dir_next;
  logic [1:0]       la_next, lb_next;
  logic             walk_next, ped_ack_next;
  logic             green_done, yellow_done, allred_done, ped_done;
  logic             a_yield, b_yield;

  assign green_done  = (timer_reg >= GREEN_LAST);
  assign yellow_done = (timer_reg == YELLOW_LAST);
  assign allred_done = (timer_reg == ALLRED_LAST);
  assign ped_done    = (timer_reg == PED_LAST);

  // A green yields once its own street is empty, a pedestrian is waiting,
  // or the other street has cars (so both-busy traffic alternates instead
  // of starving the cross street).
  assign a_yield = !Ta || Tb || ped_pend_reg;
  assign b_yield = !Tb || Ta || ped_pend_reg;

  // Next-state, direction and pedestrian-latch logic.
  always_comb begin
    state_next    = state_reg;
    next_dir_next = next_dir_reg;
    case (state_reg)
      S_AG: begin
`ifdef TL_SCHED_EMERG_EN
        if (emerg) state_next = S_AY;
        else
`endif
        if (green_done && a_yield) state_next = S_AY;
      end
      S_AY: begin
        if (yellow_done) begin
`ifdef TL_SCHED_EMERG_EN
          if (emerg) state_next = S_EMG;
          else
`endif
          state_next = S_AR1;
        end
      end
      S_AR1: begin
`ifdef TL_SCHED_EMERG_EN
        if (emerg) state_next = S_EMG;
        else
`endif
        if (allred_done) begin
          next_dir_next = DIR_B;
          state_next    = ped_pend_reg ? S_PED : S_BG;
        end
      end
      S_BG: begin
`ifdef TL_SCHED_EMERG_EN
        if (emerg) state_next = S_BY;
        else
`endif
        if (green_done && b_yield) state_next = S_BY;
      end
      S_BY: begin
        if (yellow_done) begin
`ifdef TL_SCHED_EMERG_EN
          if (emerg) state_next = S_EMG;
          else
`endif
          state_next = S_AR2;
        end
      end
      S_AR2: begin
`ifdef TL_SCHED_EMERG_EN
        if (emerg) state_next = S_EMG;
        else
`endif
        if (allred_done) begin
          next_dir_next = DIR_A;
          state_next    = ped_pend_reg ? S_PED : S_AG;
        end
      end
      S_PED: begin
`ifdef TL_SCHED_EMERG_EN
        if (emerg) state_next = S_EMG;
        else
`endif
        if (ped_done) state_next = (next_dir_reg == DIR_A) ? S_AG : S_BG;
      end
`ifdef TL_SCHED_EMERG_EN
      // Preempt exits through an all-red clearance heading back to street A.
      S_EMG: begin
        if (!emerg) state_next = S_AR2;
      end
`endif
      default: state_next = S_AG;
    endcase

    // Timer restarts with every phase and saturates in long greens.
    if (state_next != state_reg)
      timer_next = '0;
    else if (timer_reg == TIMER_MAX)
      timer_next = timer_reg;
    else
      timer_next = timer_reg + CNT_W'(1);

    // Entering WALK serves every request so far, including one on this edge.
    if (state_next == S_PED && state_reg != S_PED)
      ped_pend_next = 1'b0;
    else
      ped_pend_next = ped_pend_reg | ped_req;
  end

  // Lamp decode of the upcoming state so the outputs come straight from flops.
  always_comb begin
    la_next      = LAMP_RED;
    lb_next      = LAMP_RED;
    walk_next    = 1'b0;
    ped_ack_next = 1'b0;
    case (state_next)
      S_AG:    la_next = LAMP_GREEN;
      S_AY:    la_next = LAMP_YELLOW;
      S_BG:    lb_next = LAMP_GREEN;
      S_BY:    lb_next = LAMP_YELLOW;
      S_PED: begin
        walk_next    = 1'b1;
        ped_ack_next = (timer_next == '0);
      end
      default: begin
        la_next = LAMP_RED;
        lb_next = LAMP_RED;
      end
    endcase
  end

  // State, timer, latches and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_AG;
      timer_reg    <= '0;
      ped_pend_reg <= 1'b0;
      next_dir_reg <= DIR_B;
      La           <= LAMP_GREEN;
      Lb           <= LAMP_RED;
      walk         <= 1'b0;
      ped_ack      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      ped_pend_reg <= ped_pend_next;
      next_dir_reg <= next_dir_next;
      La           <= la_next;
      Lb           <= lb_next;
      walk         <= walk_next;
      ped_ack      <= ped_ack_next;
    end
  end

endmodule
